// File: rtl/noc.sv
// Shared NoC definitions: flit type encoding and flit field positions/widths.
package noc;

   typedef enum logic [1:0] {
      FlitBody    = 2'b00,
      FlitTail    = 2'b01,
      FlitHead    = 2'b10,
      FlitIllegal = 2'b11
   } flit_type_e;

   localparam int unsigned FlitW    = 34;
   localparam int unsigned PayloadW = 32;
   localparam int unsigned CoordW   = 3;
   localparam int unsigned TypeMsb  = 33;
   localparam int unsigned TypeLsb  = 32;
   localparam int unsigned DstXLsb  = 23;
   localparam int unsigned DstYLsb  = 20;
   localparam int unsigned SrcXLsb  = 13;
   localparam int unsigned SrcYLsb  = 10;

endpackage

// File: rtl/ni_eject_fifo.sv
// Flit input FIFO for the ejection receiver; a push at full is accepted when a pop
// happens in the same cycle.
module ni_eject_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 34
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);
   localparam int unsigned AddrW = $clog2(DEPTH);
   localparam int unsigned CntW  = AddrW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]  cnt_q;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == CntW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
         cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/ni_eject_rx.sv
// NoC ejection receiver: buffers router flits and reassembles them into payload words.
// Build macro NI_EJECT_RX_DEST_CHECK_EN drops packets whose head is not addressed here.
module ni_eject_rx
   import noc::*;
#(
   parameter int unsigned WIDTH = 34,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       CONST_localx,
   input  logic [2:0]       CONST_localy,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_void_in,
   output logic             stop_out,
   output logic [31:0]      pkt_data,
   output logic             pkt_valid,
   input  logic             pkt_ready,
   output logic             pkt_last,
   output logic [2:0]       pkt_src_x,
   output logic [2:0]       pkt_src_y,
   output logic [15:0]      pkt_count,
   output logic             err_seq,
   output logic             err_dest,
   output logic             err_ovf
);
   localparam int unsigned CntW = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {StIdle, StPkt, StDrop} state_e;

   state_e              state_q;
   logic [WIDTH-1:0]    fifo_dout;
   logic                fifo_full, fifo_empty;
   logic [CntW-1:0]     fifo_cnt, cnt_nxt;
   logic                push, push_acc, pop, ovf, out_free, dest_bad;
   flit_type_e          ftype;
   logic [PayloadW-1:0] payload;

   logic                hold_valid_q;
   logic [31:0]         hold_data_q;
   logic                stop_q, pkt_valid_q, pkt_last_q, err_seq_q, err_ovf_q;
   logic [31:0]         pkt_data_q;
   logic [2:0]          pkt_src_x_q, pkt_src_y_q;
   logic [15:0]         pkt_count_q;

   assign push     = ~data_void_in;
   assign out_free = ~pkt_valid_q | pkt_ready;
   assign pop      = ~fifo_empty & out_free;
   assign push_acc = push & (~fifo_full | pop);
   assign ovf      = push & ~push_acc;
   assign cnt_nxt  = fifo_cnt + CntW'(push_acc) - CntW'(pop);
   assign ftype    = flit_type_e'(fifo_dout[TypeMsb:TypeLsb]);
   assign payload  = fifo_dout[PayloadW-1:0];

   ni_eject_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (push),
      .data_i  (data_in),
      .pop_i   (pop),
      .data_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

`ifdef NI_EJECT_RX_DEST_CHECK_EN
   logic err_dest_q;

   assign dest_bad = (fifo_dout[DstXLsb +: CoordW] != CONST_localx) |
                     (fifo_dout[DstYLsb +: CoordW] != CONST_localy);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_dest_q <= 1'b0;
      end else if (pop && state_q == StIdle && ftype == FlitHead && dest_bad) begin
         err_dest_q <= 1'b1;
      end
   end

   assign err_dest = err_dest_q;
`else
   logic unused_coord;

   assign dest_bad     = 1'b0;
   assign unused_coord = ^{CONST_localx, CONST_localy};
   assign err_dest     = 1'b0;
`endif

   // A body word is held back one flit so the tail can mark it as the last word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         hold_valid_q <= 1'b0;
         hold_data_q  <= '0;
         stop_q       <= 1'b0;
         pkt_valid_q  <= 1'b0;
         pkt_data_q   <= '0;
         pkt_last_q   <= 1'b0;
         pkt_src_x_q  <= '0;
         pkt_src_y_q  <= '0;
         pkt_count_q  <= '0;
         err_seq_q    <= 1'b0;
         err_ovf_q    <= 1'b0;
      end else begin
         stop_q <= (cnt_nxt >= CntW'(DEPTH - 2));
         if (ovf) err_ovf_q <= 1'b1;
         if (pkt_valid_q && pkt_ready) pkt_valid_q <= 1'b0;
         if (pop) begin
            unique case (state_q)
               StIdle: begin
                  hold_valid_q <= 1'b0;
                  if (ftype == FlitHead) begin
                     state_q <= dest_bad ? StDrop : StPkt;
                  end else begin
                     err_seq_q <= 1'b1;
                  end
               end
               StPkt: begin
                  case (ftype)
                     FlitBody: begin
                        if (hold_valid_q) begin
                           pkt_valid_q <= 1'b1;
                           pkt_data_q  <= hold_data_q;
                           pkt_last_q  <= 1'b0;
                        end
                        hold_data_q  <= payload;
                        hold_valid_q <= 1'b1;
                     end
                     FlitTail: begin
                        if (hold_valid_q) begin
                           pkt_valid_q <= 1'b1;
                           pkt_data_q  <= hold_data_q;
                           pkt_last_q  <= 1'b1;
                           pkt_src_x_q <= fifo_dout[SrcXLsb +: CoordW];
                           pkt_src_y_q <= fifo_dout[SrcYLsb +: CoordW];
                        end
                        hold_valid_q <= 1'b0;
                        pkt_count_q  <= pkt_count_q + 16'd1;
                        state_q      <= StIdle;
                     end
                     default: begin
                        err_seq_q    <= 1'b1;
                        hold_valid_q <= 1'b0;
                        state_q      <= StDrop;
                     end
                  endcase
               end
               StDrop: begin
                  if (ftype == FlitTail) state_q <= StIdle;
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign stop_out  = stop_q;
   assign pkt_valid = pkt_valid_q;
   assign pkt_data  = pkt_data_q;
   assign pkt_last  = pkt_last_q;
   assign pkt_src_x = pkt_src_x_q;
   assign pkt_src_y = pkt_src_y_q;
   assign pkt_count = pkt_count_q;
   assign err_seq   = err_seq_q;
   assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_ni_eject_rx.sv
// Directed self-checking bench for ni_eject_rx with hand-computed expected words.
module tb_ni_eject_rx;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  CONST_localx = 3'd2;
   logic [2:0]  CONST_localy = 3'd2;
   logic [33:0] data_in;
   logic        data_void_in;
   logic        stop_out;
   logic [31:0] pkt_data;
   logic        pkt_valid;
   logic        pkt_ready;
   logic        pkt_last;
   logic [2:0]  pkt_src_x, pkt_src_y;
   logic [15:0] pkt_count;
   logic        err_seq, err_dest, err_ovf;

   typedef struct {
      logic [31:0] data;
      logic        last;
      logic [2:0]  sx;
      logic [2:0]  sy;
   } word_t;

   word_t rx_q[$];
   int    n_cmp = 0;
   int    n_err = 0;
   bit    stop_seen;

   always #5 clk = ~clk;

   ni_eject_rx #(
      .WIDTH (34),
      .DEPTH (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .CONST_localx (CONST_localx),
      .CONST_localy (CONST_localy),
      .data_in      (data_in),
      .data_void_in (data_void_in),
      .stop_out     (stop_out),
      .pkt_data     (pkt_data),
      .pkt_valid    (pkt_valid),
      .pkt_ready    (pkt_ready),
      .pkt_last     (pkt_last),
      .pkt_src_x    (pkt_src_x),
      .pkt_src_y    (pkt_src_y),
      .pkt_count    (pkt_count),
      .err_seq      (err_seq),
      .err_dest     (err_dest),
      .err_ovf      (err_ovf)
   );

   // Handshake sampled mid-cycle; inputs only change just after the rising edge.
   always @(negedge clk) begin
      if (pkt_valid && pkt_ready) begin
         rx_q.push_back('{data: pkt_data, last: pkt_last, sx: pkt_src_x, sy: pkt_src_y});
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   function automatic logic [33:0] mk_head(input logic [2:0] dx, input logic [2:0] dy);
      return {2'b10, 6'd0, dx, dy, 20'd0};
   endfunction

   function automatic logic [33:0] mk_body(input logic [31:0] v);
      return {2'b00, v};
   endfunction

   function automatic logic [33:0] mk_tail(input logic [2:0] sx, input logic [2:0] sy);
      return {2'b01, 16'd0, sx, sy, 10'd0};
   endfunction

   task automatic push_raw(input logic [33:0] f);
      data_in      = f;
      data_void_in = 1'b0;
      @(posedge clk);
      #1;
      data_void_in = 1'b1;
   endtask

   task automatic send(input logic [33:0] f);
      int w = 0;
      while (stop_out && w < 200) begin
         stop_seen = 1'b1;
         @(posedge clk);
         #1;
         w++;
      end
      if (w >= 200) check("stop_wait", 32'(w), 32'd0);
      push_raw(f);
   endtask

   task automatic send_pkt(input logic [2:0] dx, input logic [2:0] dy, input int base,
                           input int n, input logic [2:0] sx, input logic [2:0] sy);
      send(mk_head(dx, dy));
      for (int i = 0; i < n; i++) send(mk_body(32'(base + i)));
      send(mk_tail(sx, sy));
   endtask

   task automatic settle();
      repeat (25) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      rx_q.delete();
   endtask

   task automatic check_seq(input int base, input int n, input logic [2:0] sx,
                            input logic [2:0] sy);
      check("n_words", 32'(rx_q.size()), 32'(n));
      for (int i = 0; i < rx_q.size() && i < n; i++) begin
         check("word", rx_q[i].data, 32'(base + i));
         check("last", 32'(rx_q[i].last), 32'(i == n - 1));
         if (i == n - 1) begin
            check("src_x", 32'(rx_q[i].sx), 32'(sx));
            check("src_y", 32'(rx_q[i].sy), 32'(sy));
         end
      end
   endtask

   initial begin
      rst          = 1'b1;
      data_in      = '0;
      data_void_in = 1'b1;
      pkt_ready    = 1'b1;
      stop_seen    = 1'b0;
      @(posedge clk);
      #1;
      check("rst_stop", 32'(stop_out), 32'd0);
      check("rst_valid", 32'(pkt_valid), 32'd0);
      check("rst_data", pkt_data, 32'd0);
      check("rst_last", 32'(pkt_last), 32'd0);
      check("rst_src_x", 32'(pkt_src_x), 32'd0);
      check("rst_src_y", 32'(pkt_src_y), 32'd0);
      check("rst_count", 32'(pkt_count), 32'd0);
      check("rst_err_seq", 32'(err_seq), 32'd0);
      check("rst_err_dest", 32'(err_dest), 32'd0);
      check("rst_err_ovf", 32'(err_ovf), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Basic packet: words 1..5, last on 5.
      send_pkt(3'd2, 3'd2, 1, 5, 3'd2, 3'd2);
      settle();
      check_seq(1, 5, 3'd2, 3'd2);
      check("t1_count", 32'(pkt_count), 32'd1);
      check("t1_err_seq", 32'(err_seq), 32'd0);
      check("t1_err_ovf", 32'(err_ovf), 32'd0);

      // Back-pressure for 10 cycles; stop must rise, nothing lost.
      rx_q.delete();
      stop_seen = 1'b0;
      pkt_ready = 1'b0;
      fork
         send_pkt(3'd2, 3'd2, 1, 5, 3'd2, 3'd2);
         begin
            repeat (10) @(posedge clk);
            #1;
            pkt_ready = 1'b1;
         end
      join
      settle();
      check("t2_stop_seen", 32'(stop_seen), 32'd1);
      check_seq(1, 5, 3'd2, 3'd2);
      check("t2_count", 32'(pkt_count), 32'd2);
      check("t2_err_ovf", 32'(err_ovf), 32'd0);

      // Orphan body, then a good packet.
      do_reset();
      send(mk_body(32'd7));
      send_pkt(3'd2, 3'd2, 10, 2, 3'd1, 3'd3);
      settle();
      check("t3_err_seq", 32'(err_seq), 32'd1);
      check_seq(10, 2, 3'd1, 3'd3);
      check("t3_count", 32'(pkt_count), 32'd1);

      // Packet addressed to (3,2).
      do_reset();
      send_pkt(3'd3, 3'd2, 9, 1, 3'd4, 3'd4);
      settle();
`ifdef NI_EJECT_RX_DEST_CHECK_EN
      check("t4_err_dest", 32'(err_dest), 32'd1);
      check("t4_n_words", 32'(rx_q.size()), 32'd0);
      check("t4_count", 32'(pkt_count), 32'd0);
`else
      check("t4_err_dest", 32'(err_dest), 32'd0);
      check_seq(9, 1, 3'd4, 3'd4);
      check("t4_count", 32'(pkt_count), 32'd1);
`endif
      check("t4_err_seq", 32'(err_seq), 32'd0);

      // Head directly followed by tail.
      do_reset();
      check("t5_count0", 32'(pkt_count), 32'd0);
      send(mk_head(3'd2, 3'd2));
      send(mk_tail(3'd1, 3'd1));
      settle();
      check("t5_n_words", 32'(rx_q.size()), 32'd0);
      check("t5_count1", 32'(pkt_count), 32'd1);

      // Reset in the middle of a stalled packet.
      pkt_ready = 1'b0;
      push_raw(mk_head(3'd2, 3'd2));
      push_raw(mk_body(32'd1));
      push_raw(mk_body(32'd2));
      push_raw(mk_body(32'd3));
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("t6_rst_valid", 32'(pkt_valid), 32'd0);
      check("t6_rst_count", 32'(pkt_count), 32'd0);
      check("t6_rst_stop", 32'(stop_out), 32'd0);
      rst       = 1'b0;
      pkt_ready = 1'b1;
      rx_q.delete();
      @(posedge clk);
      #1;
      send_pkt(3'd2, 3'd2, 20, 3, 3'd5, 3'd6);
      settle();
      check_seq(20, 3, 3'd5, 3'd6);
      check("t6_count", 32'(pkt_count), 32'd1);
      check("t6_err_seq", 32'(err_seq), 32'd0);
      check("t6_err_ovf", 32'(err_ovf), 32'd0);

      // Fill the FIFO, then push and pop together at full.
      do_reset();
      pkt_ready = 1'b0;
      push_raw(mk_head(3'd2, 3'd2));
      for (int i = 1; i <= 6; i++) push_raw(mk_body(32'(i)));
      pkt_ready = 1'b1;
      push_raw(mk_body(32'd7));
      push_raw(mk_tail(3'd3, 3'd1));
      settle();
      check("t7_err_ovf", 32'(err_ovf), 32'd0);
      check_seq(1, 7, 3'd3, 3'd1);

      // Overflow: push at full with the output stalled drops body 7.
      do_reset();
      pkt_ready = 1'b0;
      push_raw(mk_head(3'd2, 3'd2));
      for (int i = 1; i <= 7; i++) push_raw(mk_body(32'(i)));
      check("t8_err_ovf", 32'(err_ovf), 32'd1);
      check("t8_stop", 32'(stop_out), 32'd1);
      pkt_ready = 1'b1;
      push_raw(mk_tail(3'd6, 3'd5));
      settle();
      check_seq(1, 6, 3'd6, 3'd5);
      check("t8_count", 32'(pkt_count), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
